phase2_pin_checker: RTL and testbench
=====================================

PHASE2_PIN_CHECKER -- requirements
Module: phase2_pin_checker

Interface
REQ-001 Parameter PIN, default 16'h2580, meaning the expected 4-digit BCD code with the first digit in bits [15:12].
REQ-002 Parameter MAX_ATTEMPTS, default 3, meaning wrong entries allowed before lockout; legal range is 1..3.
REQ-003 Parameter TIMEOUT_CYCLES, default 1000, meaning idle cycles allowed mid-entry; minimum is 2.
REQ-004 The block SHALL use clock clk, and reset reset, which is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 phase1_done  input  1  level from the upstream serial-code stage; high means phase 1 is passed.
REQ-008 digit_valid  input  1  single-cycle strobe qualifying digit.
REQ-009 digit  input  4  keypad digit in BCD.
REQ-010 clear  input  1  discards the partial entry.
REQ-011 entry_active  output  1  high while the block is accepting digits.
REQ-012 digit_count  output  3  digits accepted in the current attempt, range 0..4.
REQ-013 attempts_left  output  2  remaining wrong entries allowed.
REQ-014 error_pulse  output  1  one-cycle flag on a mismatch or a timeout.
REQ-015 phase2_done  output  1  sticky flag: code accepted.
REQ-016 phase2_fail  output  1  sticky flag: lockout.

Function
REQ-017 The FSM SHALL have five states: IDLE, ENTRY, CHECK, DONE and LOCKOUT. All outputs SHALL be registered.
REQ-018 In IDLE, phase1_done=1 sampled at a clock edge SHALL move the FSM to ENTRY at that edge, with digit_count=0 and timer=0.
REQ-019 In ENTRY, digit_valid=1 with digit<=9 SHALL shift the digit into a 16-bit entry register, increment digit_count and clear the timer.
REQ-020 A digit above 9 SHALL be ignored: no count change, no error_pulse, and the timer keeps running.
REQ-021 clear=1 in ENTRY SHALL zero digit_count and the timer, consume no attempt, and take priority over digit_valid in the same cycle.
REQ-022 The edge that accepts the 4th digit SHALL move the FSM to CHECK. CHECK SHALL last exactly one cycle and compare the entry register against PIN.
REQ-023 On a match, CHECK SHALL go to DONE, so phase2_done is high 2 edges after the 4th digit is sampled.
REQ-024 On a mismatch with attempts_left>1, CHECK SHALL decrement attempts_left, pulse error_pulse for 1 cycle, and return to ENTRY with digit_count=0.
REQ-025 On a mismatch with attempts_left=1, CHECK SHALL set attempts_left=0, pulse error_pulse, and go to LOCKOUT.
REQ-026 Timeout: in ENTRY with digit_count>0, the timer SHALL count every cycle that has no accepted digit.
REQ-027 When the timer reaches TIMEOUT_CYCLES-1, the block SHALL discard the entry and consume one attempt with the same rules as a mismatch; this action does not pass through CHECK.
REQ-028 The timer SHALL be held at 0 while digit_count=0.
REQ-029 If a timeout and an accepted digit coincide, the digit SHALL win and the timer SHALL clear.
REQ-030 DONE SHALL hold phase2_done=1, and LOCKOUT SHALL hold phase2_fail=1, until reset. All inputs SHALL be ignored in both states.
REQ-031 If phase1_done falls while the FSM is in ENTRY or CHECK, the FSM SHALL return to IDLE, reload attempts_left to MAX_ATTEMPTS and zero digit_count; no error_pulse is issued.
REQ-032 digit_valid SHALL be ignored in IDLE, CHECK, DONE and LOCKOUT.
REQ-033 entry_active SHALL be 1 exactly in ENTRY, and phase2_done and phase2_fail SHALL never be high together.

Reset
REQ-034 Reset SHALL put the FSM in IDLE, set the entry register, timer and digit_count to 0, set attempts_left to MAX_ATTEMPTS, and drive entry_active, error_pulse, phase2_done and phase2_fail to 0.
REQ-035 Reset asserted in any state, including DONE or LOCKOUT or mid-entry, SHALL take effect immediately without waiting for a clock edge.

Verification (PIN=16'h2580, MAX_ATTEMPTS=3, TIMEOUT_CYCLES=16)
REQ-036 Raise phase1_done, then enter digits 2,5,8,0 -> phase2_done=1 two edges after the 0 is sampled; attempts_left stays 3.
REQ-037 Enter 2,5,8,1 -> error_pulse for 1 cycle, attempts_left=2, digit_count=0; then enter 2,5,8,0 -> phase2_done=1.
REQ-038 Make three wrong entries -> attempts_left goes 2, 1, 0, then phase2_fail=1; further digit strobes -> no change.
REQ-039 Enter 2,5, then idle for 15 cycles -> error_pulse, attempts_left=2, digit_count=0; with digit 0 held at 0 and no strobes -> no timeout fires.
REQ-040 Enter 2,5, assert clear together with digit_valid carrying 8 -> digit_count=0 and attempts_left=3; enter digit 12 -> ignored.
REQ-041 Assert reset mid-entry or in LOCKOUT -> immediate IDLE, attempts_left=3, all flags 0; drop phase1_done mid-entry -> IDLE with attempts_left reloaded.

Source files
------------

// File: rtl/phase2_pin_checker.sv
// Second-stage keypad lock: collects four BCD digits once phase 1 is passed and
// compares them to PIN, with a bounded number of wrong or timed-out attempts.
module phase2_pin_checker #(
    parameter logic [15:0] PIN            = 16'h2580,
    parameter int          MAX_ATTEMPTS   = 3,
    parameter int          TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       phase1_done,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       clear,
    output logic       entry_active,
    output logic [2:0] digit_count,
    output logic [1:0] attempts_left,
    output logic       error_pulse,
    output logic       phase2_done,
    output logic       phase2_fail
);

    localparam int             TW         = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_CYCLES - 2);
    localparam logic [1:0]     ATT_INIT   = 2'(MAX_ATTEMPTS);

    typedef enum logic [2:0] {IDLE, ENTRY, CHECK, DONE, LOCKOUT} state_t;

    state_t          state;
    logic [15:0]     entry_reg;
    logic [TW-1:0]   timer;
    logic            digit_ok;
    logic            timeout_hit;
    logic            mismatch;
    logic            penalty;

    assign digit_ok = digit_valid && (digit <= 4'd9);

    // A timeout only fires on a cycle where nothing with higher priority happens
    // (phase 1 drop, clear, accepted digit); this edge brings the timer to its last value.
    assign timeout_hit = (state == ENTRY) && phase1_done && !clear && !digit_ok &&
                         (digit_count != 3'd0) && (timer == TIMER_LAST);
    assign mismatch    = (state == CHECK) && phase1_done && (entry_reg != PIN);
    assign penalty     = timeout_hit || mismatch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            entry_reg     <= '0;
            timer         <= '0;
            digit_count   <= '0;
            attempts_left <= ATT_INIT;
            entry_active  <= 1'b0;
            error_pulse   <= 1'b0;
            phase2_done   <= 1'b0;
            phase2_fail   <= 1'b0;
        end else begin
            error_pulse <= 1'b0;
            if (penalty) begin
                error_pulse <= 1'b1;
                digit_count <= '0;
                timer       <= '0;
                if (attempts_left > 2'd1) begin
                    attempts_left <= attempts_left - 2'd1;
                    state         <= ENTRY;
                    entry_active  <= 1'b1;
                end else begin
                    attempts_left <= '0;
                    state         <= LOCKOUT;
                    entry_active  <= 1'b0;
                    phase2_fail   <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (phase1_done) begin
                            state        <= ENTRY;
                            entry_active <= 1'b1;
                            digit_count  <= '0;
                            timer        <= '0;
                        end
                    end
                    ENTRY, CHECK: begin
                        if (!phase1_done) begin
                            state         <= IDLE;
                            entry_active  <= 1'b0;
                            attempts_left <= ATT_INIT;
                            digit_count   <= '0;
                            timer         <= '0;
                        end else if (state == CHECK) begin
                            // mismatches are taken by the penalty path above
                            state       <= DONE;
                            phase2_done <= 1'b1;
                        end else if (clear) begin
                            digit_count <= '0;
                            timer       <= '0;
                        end else if (digit_ok) begin
                            entry_reg   <= {entry_reg[11:0], digit};
                            digit_count <= digit_count + 3'd1;
                            timer       <= '0;
                            if (digit_count == 3'd3) begin
                                state        <= CHECK;
                                entry_active <= 1'b0;
                            end
                        end else if (digit_count != 3'd0) begin
                            timer <= timer + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_phase2_pin_checker.sv
// Bench for phase2_pin_checker: directed scenarios then random traffic, all
// checked each cycle against a queue-based model of the keypad lock.
module tb_phase2_pin_checker;

    localparam logic [15:0] PINV = 16'h2580;
    localparam int          MAXA = 3;
    localparam int          TO   = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       phase1_done;
    logic       digit_valid;
    logic [3:0] digit;
    logic       clear;
    logic       entry_active;
    logic [2:0] digit_count;
    logic [1:0] attempts_left;
    logic       error_pulse;
    logic       phase2_done;
    logic       phase2_fail;

    phase2_pin_checker #(.PIN(PINV), .MAX_ATTEMPTS(MAXA), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .phase1_done(phase1_done), .digit_valid(digit_valid),
        .digit(digit), .clear(clear), .entry_active(entry_active), .digit_count(digit_count),
        .attempts_left(attempts_left), .error_pulse(error_pulse),
        .phase2_done(phase2_done), .phase2_fail(phase2_fail)
    );

    always #5 clk = ~clk;

    int npass  = 0;
    int ntotal = 0;

    // model: 0 idle, 1 entering, 2 checking, 3 accepted, 4 locked out
    int m_mode;
    int m_q[$];
    int m_idle;
    int m_att;
    bit m_err;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        ntotal++;
        assert (got === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_all();
        chk("entry_active",  16'(entry_active),  16'(m_mode == 1));
        chk("digit_count",   16'(digit_count),   16'(m_q.size()));
        chk("attempts_left", 16'(attempts_left), 16'(m_att));
        chk("error_pulse",   16'(error_pulse),   16'(m_err));
        chk("phase2_done",   16'(phase2_done),   16'(m_mode == 3));
        chk("phase2_fail",   16'(phase2_fail),   16'(m_mode == 4));
    endtask

    function automatic void model_reset();
        m_mode = 0; m_q.delete(); m_idle = 0; m_att = MAXA; m_err = 0;
    endfunction

    function automatic void penalize();
        m_err = 1; m_q.delete(); m_idle = 0;
        if (m_att > 1) begin m_att--; m_mode = 1; end
        else begin m_att = 0; m_mode = 4; end
    endfunction

    function automatic void model_edge(input bit p1, input bit dv, input int d, input bit clr);
        int code;
        m_err = 0;
        case (m_mode)
            0: if (p1) begin m_mode = 1; m_q.delete(); m_idle = 0; end
            1, 2: begin
                if (!p1) begin
                    m_mode = 0; m_att = MAXA; m_q.delete(); m_idle = 0;
                end else if (m_mode == 2) begin
                    code = m_q[0] * 4096 + m_q[1] * 256 + m_q[2] * 16 + m_q[3];
                    if (code == int'(PINV)) m_mode = 3;
                    else penalize();
                end else if (clr) begin
                    m_q.delete(); m_idle = 0;
                end else if (dv && d <= 9) begin
                    m_q.push_back(d); m_idle = 0;
                    if (m_q.size() == 4) m_mode = 2;
                end else if (m_q.size() > 0) begin
                    m_idle++;
                    if (m_idle == TO - 1) penalize();
                end
            end
            default: ;
        endcase
    endfunction

    task automatic cycle(input bit p1, input bit dv, input logic [3:0] d, input bit clr);
        @(negedge clk);
        phase1_done = p1; digit_valid = dv; digit = d; clear = clr;
        @(posedge clk);
        model_edge(p1, dv, int'(d), clr);
        #1;
        check_all();
    endtask

    task automatic key(input logic [3:0] d);
        cycle(1'b1, 1'b1, d, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b1, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic enter4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                          input logic [3:0] d);
        key(a); key(b); key(c); key(d);
    endtask

    // reset raised between edges must show up before the next rising edge
    task automatic async_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        model_reset();
        #1 check_all();
        @(negedge clk);
        reset = 1'b0; phase1_done = 1'b0; digit_valid = 1'b0; clear = 1'b0; digit = 4'd0;
    endtask

    initial begin
        int dv_pct;
        logic [3:0] d;
        reset = 1'b1; phase1_done = 1'b0; digit_valid = 1'b0; digit = 4'd0; clear = 1'b0;
        model_reset();
        #3 check_all();
        @(negedge clk) reset = 1'b0;

        // correct code first time
        cycle(1'b1, 1'b0, 4'd0, 1'b0);
        enter4(4'd2, 4'd5, 4'd8, 4'd0);
        chk("done_not_yet", 16'(phase2_done), 16'd0);
        idle(1);
        chk("done_two_edges", 16'(phase2_done), 16'd1);
        key(4'd3); key(4'd7); idle(2);
        async_reset();

        // one wrong, then right
        cycle(1'b1, 1'b0, 4'd0, 1'b0);
        enter4(4'd2, 4'd5, 4'd8, 4'd1);
        idle(2);
        enter4(4'd2, 4'd5, 4'd8, 4'd0);
        idle(2);
        async_reset();

        // three wrong entries to lockout, then strobes ignored
        cycle(1'b1, 1'b0, 4'd0, 1'b0);
        repeat (3) begin enter4(4'd1, 4'd1, 4'd1, 4'd1); idle(1); end
        chk("lockout_fail", 16'(phase2_fail), 16'd1);
        enter4(4'd2, 4'd5, 4'd8, 4'd0); idle(2);
        async_reset();

        // timeout after two digits, then no timeout while count is zero
        cycle(1'b1, 1'b0, 4'd0, 1'b0);
        key(4'd2); key(4'd5);
        idle(14);
        chk("no_early_timeout", 16'(error_pulse), 16'd0);
        idle(1);
        chk("timeout_pulse", 16'(error_pulse), 16'd1);
        idle(40);
        async_reset();

        // clear beats digit; digit above 9 ignored
        cycle(1'b1, 1'b0, 4'd0, 1'b0);
        key(4'd2); key(4'd5);
        cycle(1'b1, 1'b1, 4'd8, 1'b1);
        key(4'd12); key(4'd4); key(4'd15); idle(3);
        async_reset();

        // reset mid-entry, reset in lockout, phase 1 drop mid-entry
        cycle(1'b1, 1'b0, 4'd0, 1'b0);
        key(4'd2);
        async_reset();
        cycle(1'b1, 1'b0, 4'd0, 1'b0);
        repeat (3) begin enter4(4'd9, 4'd9, 4'd9, 4'd9); idle(1); end
        async_reset();
        cycle(1'b1, 1'b0, 4'd0, 1'b0);
        enter4(4'd0, 4'd0, 4'd0, 4'd0); idle(1);
        key(4'd2);
        cycle(1'b0, 1'b1, 4'd5, 1'b0);
        chk("drop_reload", 16'(attempts_left), 16'(MAXA));
        idle(2);

        // random traffic, mostly steering toward the correct code
        dv_pct = 60;
        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) dv_pct = ($urandom_range(0, 1) == 0) ? 10 : 60;
            if ((m_mode == 3 || m_mode == 4) && $urandom_range(0, 9) == 0) begin
                async_reset();
            end else begin
                if ($urandom_range(0, 9) < 7 && m_q.size() < 4)
                    d = PINV[15 - 4 * m_q.size() -: 4];
                else
                    d = 4'($urandom_range(0, 15));
                cycle($urandom_range(0, 59) != 0, $urandom_range(0, 99) < dv_pct, d,
                      $urandom_range(0, 99) < 3);
            end
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
